// File: rtl/packet_ejector.sv
// Local-port packet sink: credit-managed flit FIFO, packet reassembly with integrity checks and a per-packet summary record.
// Optional tail checksum verification is enabled by defining PACKET_EJECTOR_CHECKSUM_EN.
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 32
`endif
`ifndef FLIT_FLAGS_WIDTH
`define FLIT_FLAGS_WIDTH 4
`endif
`ifndef FLIT_ID_WIDTH
`define FLIT_ID_WIDTH 4
`endif
`ifndef FLIT_SRC_WIDTH
`define FLIT_SRC_WIDTH 4
`endif
`ifndef FLIT_DST_WIDTH
`define FLIT_DST_WIDTH 4
`endif
`ifndef FLIT_CHECKSUM_WIDTH
`define FLIT_CHECKSUM_WIDTH 20
`endif
`ifndef BUFFERSIZE
`define BUFFERSIZE 4
`endif
`ifndef BUFFERSIZE_WIDTH
`define BUFFERSIZE_WIDTH 3
`endif

module packet_ejector #(
  parameter logic [`FLIT_DST_WIDTH-1:0]      P_LOCAL_ID = '0,
  parameter logic [1:0]                      P_HEADFLIT = 2'b10,
  parameter logic [1:0]                      P_BODYFLIT = 2'b11,
  parameter logic [1:0]                      P_TAILFLIT = 2'b01,
  parameter int                              P_MAX_BODY = 5,
  parameter logic [`FLIT_CHECKSUM_WIDTH-1:0] P_CHECKSUM = 20'hF0F0F
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         data_valid,
  input  logic [`FLIT_WIDTH-1:0]       data_in,
  input  logic                         drain_en,
  output logic [`BUFFERSIZE_WIDTH-1:0] credit_feedback,
  output logic                         packet_valid,
  output logic [`FLIT_SRC_WIDTH-1:0]   packet_src,
  output logic [`FLIT_ID_WIDTH-1:0]    packet_id,
  output logic [`BUFFERSIZE_WIDTH-1:0] packet_flits,
  output logic                         packet_error,
  output logic [2:0]                   error_code,
  output logic                         overflow
);

  localparam int FW    = `FLIT_WIDTH;
  localparam int FFW   = `FLIT_FLAGS_WIDTH;
  localparam int IDW   = `FLIT_ID_WIDTH;
  localparam int SW    = `FLIT_SRC_WIDTH;
  localparam int DW    = `FLIT_DST_WIDTH;
  localparam int CW    = `FLIT_CHECKSUM_WIDTH;
  localparam int DEPTH = `BUFFERSIZE;
  localparam int BW    = `BUFFERSIZE_WIDTH;
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] E_NONE    = 3'd0;
  localparam logic [2:0] E_NOHEAD  = 3'd1;
  localparam logic [2:0] E_DST     = 3'd2;
  localparam logic [2:0] E_ID      = 3'd3;
  localparam logic [2:0] E_LONG    = 3'd4;
  localparam logic [2:0] E_HEADIN  = 3'd5;
  localparam logic [2:0] E_CKSUM   = 3'd6;

  typedef enum logic [1:0] {S_HEAD, S_BODY, S_DISCARD, S_REPORT} state_t;

  state_t          state_q;
  logic [FW-1:0]   mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [BW-1:0]   count_q, count_d, credit_q;
  logic            overflow_q;
  logic            full, empty, push, pop;

  logic [SW-1:0]   src_q, pend_src_q, pkt_src_q;
  logic [IDW-1:0]  id_q, pend_id_q, pkt_id_q;
  logic [BW-1:0]   cnt_q, cnt_inc, pkt_flits_q;
  logic [2:0]      err_q, pend_err_q, pkt_code_q;
  logic            pend_vld_q, pkt_vld_q, pkt_err_q;

  logic [FW-1:0]   flit;
  logic [1:0]      f_type;
  logic [SW-1:0]   f_src;
  logic [DW-1:0]   f_dst;
  logic [IDW-1:0]  f_id;
  logic [CW-1:0]   f_cks;
  logic            id_bad, dst_bad, cks_bad, too_long;
  logic [2:0]      body_code, tail_code;
  logic            rpt_go, hold_head;
  logic [BW-1:0]   rpt_flits;
  logic [2:0]      rpt_code;
  logic            unused_bits;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count_q == BW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = data_valid & ~full;
  assign pop   = drain_en & ~empty & (state_q != S_REPORT);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= data_in;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      credit_q   <= BW'(DEPTH);
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= ptr_next(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_next(rd_ptr_q);
      count_q  <= count_d;
      credit_q <= BW'(DEPTH) - count_d;
      // full is sampled before any same-cycle pop, so a push at full is always lost
      if (data_valid && full) overflow_q <= 1'b1;
    end
  end

  assign flit   = mem_q[rd_ptr_q];
  assign f_type = flit[FW-1 -: 2];
  assign f_src  = flit[FW-3 -: SW];
  assign f_dst  = flit[FW-3-SW -: DW];
  assign f_id   = flit[FFW +: IDW];
  assign f_cks  = flit[FW-3 -: CW];
  assign unused_bits = ^{flit, f_cks, P_CHECKSUM};

  assign id_bad   = (f_id != id_q);
  assign dst_bad  = (f_dst != P_LOCAL_ID);
`ifdef PACKET_EJECTOR_CHECKSUM_EN
  assign cks_bad  = (f_cks != P_CHECKSUM);
`else
  assign cks_bad  = 1'b0;
`endif
  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign too_long = (int'(cnt_q) > P_MAX_BODY);

  always_comb begin
    body_code = err_q;
    if (err_q == E_NONE && id_bad) body_code = E_ID;
    tail_code = body_code;
    if (body_code == E_NONE && cks_bad) tail_code = E_CKSUM;
  end

  // Decide whether the popped flit closes the current packet
  always_comb begin
    rpt_go    = 1'b0;
    hold_head = 1'b0;
    rpt_flits = cnt_inc;
    rpt_code  = err_q;
    if (pop && (state_q == S_BODY || state_q == S_DISCARD)) begin
      if (f_type == P_TAILFLIT) begin
        rpt_go   = 1'b1;
        rpt_code = (state_q == S_BODY) ? tail_code : err_q;
      end else if (f_type == P_HEADFLIT) begin
        rpt_go    = 1'b1;
        hold_head = 1'b1;
        rpt_flits = cnt_q;
        rpt_code  = (err_q == E_NONE) ? E_HEADIN : err_q;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_HEAD;
      src_q       <= '0;
      id_q        <= '0;
      cnt_q       <= '0;
      err_q       <= E_NONE;
      pend_vld_q  <= 1'b0;
      pend_src_q  <= '0;
      pend_id_q   <= '0;
      pend_err_q  <= E_NONE;
      pkt_vld_q   <= 1'b0;
      pkt_src_q   <= '0;
      pkt_id_q    <= '0;
      pkt_flits_q <= '0;
      pkt_err_q   <= 1'b0;
      pkt_code_q  <= E_NONE;
    end else begin
      pkt_vld_q <= rpt_go;
      case (state_q)
        S_HEAD: if (pop) begin
          cnt_q <= BW'(1);
          if (f_type == P_HEADFLIT) begin
            src_q   <= f_src;
            id_q    <= f_id;
            err_q   <= dst_bad ? E_DST : E_NONE;
            state_q <= S_BODY;
          end else begin
            src_q   <= '0;
            id_q    <= '0;
            err_q   <= E_NOHEAD;
            state_q <= S_DISCARD;
          end
        end
        S_BODY: if (pop && f_type == P_BODYFLIT) begin
          cnt_q <= cnt_inc;
          if (too_long) begin
            err_q   <= (body_code == E_NONE) ? E_LONG : body_code;
            state_q <= S_DISCARD;
          end else begin
            err_q   <= body_code;
          end
        end
        S_DISCARD: if (pop && f_type != P_TAILFLIT && f_type != P_HEADFLIT) begin
          cnt_q <= cnt_inc;
        end
        S_REPORT: begin
          if (pend_vld_q) begin
            src_q      <= pend_src_q;
            id_q       <= pend_id_q;
            err_q      <= pend_err_q;
            cnt_q      <= BW'(1);
            pend_vld_q <= 1'b0;
            state_q    <= S_BODY;
          end else begin
            state_q    <= S_HEAD;
          end
        end
        default: state_q <= S_HEAD;
      endcase
      if (rpt_go) begin
        pkt_src_q   <= src_q;
        pkt_id_q    <= id_q;
        pkt_flits_q <= rpt_flits;
        pkt_code_q  <= rpt_code;
        pkt_err_q   <= (rpt_code != E_NONE);
        state_q     <= S_REPORT;
      end
      // A head that interrupts a packet waits here until the report cycle is over
      if (hold_head) begin
        pend_vld_q <= 1'b1;
        pend_src_q <= f_src;
        pend_id_q  <= f_id;
        pend_err_q <= dst_bad ? E_DST : E_NONE;
      end
    end
  end

  assign credit_feedback = credit_q;
  assign overflow        = overflow_q;
  assign packet_valid    = pkt_vld_q;
  assign packet_src      = pkt_src_q;
  assign packet_id       = pkt_id_q;
  assign packet_flits    = pkt_flits_q;
  assign packet_error    = pkt_err_q;
  assign error_code      = pkt_code_q;

endmodule

// File: tb/tb_packet_ejector.sv
// Directed bench for packet_ejector: hand-computed summary records, credit and overflow behaviour.
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 32
`endif
`ifndef FLIT_FLAGS_WIDTH
`define FLIT_FLAGS_WIDTH 4
`endif
`ifndef FLIT_ID_WIDTH
`define FLIT_ID_WIDTH 4
`endif
`ifndef FLIT_SRC_WIDTH
`define FLIT_SRC_WIDTH 4
`endif
`ifndef FLIT_DST_WIDTH
`define FLIT_DST_WIDTH 4
`endif
`ifndef FLIT_CHECKSUM_WIDTH
`define FLIT_CHECKSUM_WIDTH 20
`endif
`ifndef BUFFERSIZE
`define BUFFERSIZE 4
`endif
`ifndef BUFFERSIZE_WIDTH
`define BUFFERSIZE_WIDTH 3
`endif

module tb_packet_ejector;

`ifdef PACKET_EJECTOR_CHECKSUM_EN
  localparam int EXP_CKS = 6;
`else
  localparam int EXP_CKS = 0;
`endif
  localparam logic [19:0] GOOD = 20'hF0F0F;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        data_valid = 1'b0;
  logic [31:0] data_in = '0;
  logic        drain_en = 1'b0;
  logic [2:0]  credit_feedback;
  logic        packet_valid;
  logic [3:0]  packet_src;
  logic [3:0]  packet_id;
  logic [2:0]  packet_flits;
  logic        packet_error;
  logic [2:0]  error_code;
  logic        overflow;

  packet_ejector dut (
    .CLK(CLK), .RST(RST), .data_valid(data_valid), .data_in(data_in), .drain_en(drain_en),
    .credit_feedback(credit_feedback), .packet_valid(packet_valid), .packet_src(packet_src),
    .packet_id(packet_id), .packet_flits(packet_flits), .packet_error(packet_error),
    .error_code(error_code), .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  logic [3:0] r_src [32];
  logic [3:0] r_id [32];
  logic [2:0] r_flits [32];
  logic       r_err [32];
  logic [2:0] r_code [32];
  int         rpt_n = 0;

  // One entry per cycle that packet_valid is high, so a stretched pulse shows up as an extra report
  always @(negedge CLK) begin
    if (packet_valid === 1'b1) begin
      if (rpt_n < 32) begin
        r_src[rpt_n]   = packet_src;
        r_id[rpt_n]    = packet_id;
        r_flits[rpt_n] = packet_flits;
        r_err[rpt_n]   = packet_error;
        r_code[rpt_n]  = error_code;
      end
      rpt_n = rpt_n + 1;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rpt(input string tag, input int idx, input int src, input int id,
                           input int flits, input int err, input int code);
    int i;
    i = (idx < 32) ? idx : 31;
    check({tag, "_src"},   32'(r_src[i]),   32'(src));
    check({tag, "_id"},    32'(r_id[i]),    32'(id));
    check({tag, "_flits"}, 32'(r_flits[i]), 32'(flits));
    check({tag, "_err"},   32'(r_err[i]),   32'(err));
    check({tag, "_code"},  32'(r_code[i]),  32'(code));
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [31:0] f);
    data_valid = 1'b1;
    data_in    = f;
    tick();
    data_valid = 1'b0;
    data_in    = '0;
  endtask

  function automatic logic [31:0] hd(input logic [3:0] src, input logic [3:0] dst, input logic [3:0] id);
    return {2'b10, src, dst, 14'b0, id, 4'b0};
  endfunction

  function automatic logic [31:0] bd(input logic [3:0] id);
    return {2'b11, 22'b0, id, 4'b0};
  endfunction

  function automatic logic [31:0] tl(input logic [3:0] id, input logic [19:0] cks);
    return {2'b01, cks, 2'b0, id, 4'b0};
  endfunction

  int n0;

  initial begin
    // reset state
    idle(3);
    check("rst_credit", 32'(credit_feedback), 32'd4);
    check("rst_valid", 32'(packet_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_flits", 32'(packet_flits), 32'd0);
    check("rst_code", 32'(error_code), 32'd0);
    check("rst_error", 32'(packet_error), 32'd0);
    RST = 1'b1;
    tick();

    // clean packet
    drain_en = 1'b1;
    n0 = rpt_n;
    send(hd(4'd3, 4'd0, 4'd7)); send(bd(4'd7)); send(bd(4'd7)); send(tl(4'd7, GOOD));
    idle(6);
    check("ok_count", 32'(rpt_n), 32'(n0 + 1));
    check_rpt("ok", n0, 3, 7, 4, 0, 0);
    check("ok_credit", 32'(credit_feedback), 32'd4);
    check("ok_valid_low", 32'(packet_valid), 32'd0);
    check("ok_held_flits", 32'(packet_flits), 32'd4);

    // fill FIFO with drain off, then one extra flit
    drain_en = 1'b0;
    n0 = rpt_n;
    send(hd(4'd1, 4'd0, 4'd5)); send(bd(4'd5)); send(bd(4'd5));
    check("fill_credit1", 32'(credit_feedback), 32'd1);
    send(bd(4'd5));
    check("fill_credit0", 32'(credit_feedback), 32'd0);
    check("fill_no_ovf", 32'(overflow), 32'd0);
    send(tl(4'd5, GOOD));
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_credit", 32'(credit_feedback), 32'd0);
    drain_en = 1'b1;
    idle(6);
    check("ovf_no_report", 32'(rpt_n), 32'(n0));
    check("ovf_credit_back", 32'(credit_feedback), 32'd4);
    send(tl(4'd5, GOOD));
    idle(5);
    check("ovf_count", 32'(rpt_n), 32'(n0 + 1));
    check_rpt("ovf", n0, 1, 5, 5, 0, 0);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // id mismatch in a body flit
    n0 = rpt_n;
    send(hd(4'd3, 4'd0, 4'd7)); send(bd(4'd8)); send(tl(4'd7, GOOD));
    idle(6);
    check("idm_count", 32'(rpt_n), 32'(n0 + 1));
    check_rpt("idm", n0, 3, 7, 3, 1, 3);

    // stream without head
    n0 = rpt_n;
    send(bd(4'd4)); send(tl(4'd4, GOOD));
    idle(6);
    check("nohead_count", 32'(rpt_n), 32'(n0 + 1));
    check("nohead_err", 32'(r_err[n0]), 32'd1);
    check("nohead_code", 32'(r_code[n0]), 32'd1);

    // head inside a packet starts the next one
    n0 = rpt_n;
    send(hd(4'd2, 4'd0, 4'd7)); send(bd(4'd7));
    send(hd(4'd2, 4'd0, 4'd9)); send(bd(4'd9)); send(tl(4'd9, GOOD));
    idle(8);
    check("hin_count", 32'(rpt_n), 32'(n0 + 2));
    check_rpt("hin_first", n0, 2, 7, 2, 1, 5);
    check_rpt("hin_second", n0 + 1, 2, 9, 3, 0, 0);

    // zero checksum in the tail
    n0 = rpt_n;
    send(hd(4'd3, 4'd0, 4'd7)); send(bd(4'd7)); send(tl(4'd7, 20'h00000));
    idle(6);
    check("cks_count", 32'(rpt_n), 32'(n0 + 1));
    check_rpt("cks", n0, 3, 7, 3, (EXP_CKS != 0) ? 1 : 0, EXP_CKS);

    // head addressed to another router
    n0 = rpt_n;
    send(hd(4'd3, 4'd1, 4'd7)); send(tl(4'd7, GOOD));
    idle(6);
    check("dst_count", 32'(rpt_n), 32'(n0 + 1));
    check_rpt("dst", n0, 3, 7, 2, 1, 2);

    // exactly the maximum number of body flits
    n0 = rpt_n;
    send(hd(4'd3, 4'd0, 4'd7));
    repeat (5) send(bd(4'd7));
    send(tl(4'd7, GOOD));
    idle(6);
    check("max_count", 32'(rpt_n), 32'(n0 + 1));
    check_rpt("max", n0, 3, 7, 7, 0, 0);

    // one body flit too many; flit count saturates
    n0 = rpt_n;
    send(hd(4'd3, 4'd0, 4'd7));
    repeat (6) send(bd(4'd7));
    send(tl(4'd7, GOOD));
    idle(6);
    check("long_count", 32'(rpt_n), 32'(n0 + 1));
    check_rpt("long", n0, 3, 7, 7, 1, 4);

    // reset in the middle of a packet
    drain_en = 1'b0;
    send(hd(4'd3, 4'd0, 4'd7)); send(bd(4'd7));
    check("mid_credit_pre", 32'(credit_feedback), 32'd2);
    n0 = rpt_n;
    #2 RST = 1'b0;
    #1;
    check("mid_credit_rst", 32'(credit_feedback), 32'd4);
    check("mid_ovf_rst", 32'(overflow), 32'd0);
    check("mid_flits_rst", 32'(packet_flits), 32'd0);
    tick();
    RST = 1'b1;
    tick();
    drain_en = 1'b1;
    send(tl(4'd7, GOOD));
    idle(6);
    check("mid_no_report", 32'(rpt_n), 32'(n0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/packet_ejector.md
Name: packet_ejector

Overview:
- Local-port sink that receives flit streams from the router's local output, i.e. the traffic packet injectors send across the mesh.
- Buffers incoming flits in a credit-managed FIFO and returns the free-slot count as credit feedback.
- Reassembles head/body/tail sequences and checks protocol integrity.
- Reports one summary record per packet to the testbench/statistics logic.

Parameters:
- P_LOCAL_ID, 0, router position; head-flit destination must equal this.
- P_HEADFLIT, 2'b10, head flit type code.
- P_BODYFLIT, 2'b11, body flit type code.
- P_TAILFLIT, 2'b01, tail flit type code.
- P_MAX_BODY, 5, maximum body flits per packet.
- P_CHECKSUM, 20'hF0F0F, expected tail checksum field.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, asynchronous, active-low.
- data_valid  in  1  flit on data_in is valid this cycle.
- data_in  in  `FLIT_WIDTH  incoming flit. Field layout:
  - type [FLIT_WIDTH-1:FLIT_WIDTH-2]
  - flags [`FLIT_FLAGS_WIDTH-1:0]
  - id directly above flags
  - head: src and dst directly below type
  - tail: checksum directly below type
- drain_en  in  1  allows the assembler to pop one flit per cycle.
- credit_feedback  out  `BUFFERSIZE_WIDTH  registered free-slot count.
- packet_valid  out  1  one-cycle pulse, summary outputs valid.
- packet_src  out  `FLIT_SRC_WIDTH  source from head flit.
- packet_id  out  `FLIT_ID_WIDTH  id from head flit.
- packet_flits  out  `BUFFERSIZE_WIDTH  total flits including head and tail.
- packet_error  out  1  packet failed a check.
- error_code  out  3  first error: 1 no head, 2 wrong dst, 3 id mismatch, 4 too long, 5 head inside packet, 6 checksum.
- overflow  out  1  sticky: a flit arrived while FIFO full.

Behaviour:
- Reset (RST low, async):
  - FIFO empty; credit_feedback=`BUFFERSIZE.
  - All summary outputs 0; overflow 0; FSM to S_HEAD.
  - Reset mid-packet discards everything; no packet_valid is produced.
- FIFO:
  - Depth `BUFFERSIZE; read/write pointers wrap modulo depth.
  - Write when data_valid and not full. data_valid while full drops the flit and sets overflow (cleared only by reset).
  - Simultaneous push and pop when full: push is still dropped (full evaluated pre-pop).
  - Simultaneous push and pop otherwise: count unchanged.
- credit_feedback: registered `BUFFERSIZE-count, updated the cycle after each push/pop.
- Latency: a flit written at edge N can be popped at edge N+1 at the earliest.
- Pop: only when drain_en=1 and FIFO not empty, one flit per cycle.
- FSM (advances only on a pop, except S_REPORT):
  - S_HEAD:
    - Head popped: capture src, id; count=1; clear error; go to S_BODY.
    - If head dst≠P_LOCAL_ID, set error 2 but continue reassembly.
    - Non-head popped: error 1; go to S_DISCARD.
  - S_BODY:
    - Body popped: count+1. If id≠captured, error 3 (first error wins). If body count>P_MAX_BODY, error 4, go to S_DISCARD.
    - Tail popped: count+1; id check as for body; go to S_REPORT.
    - Head popped: report the current packet with error 5 via S_REPORT, and this head starts the next packet. The head's fields are held in a pending register and consumed in S_REPORT's exit to S_BODY.
  - S_DISCARD:
    - Pop and drop flits until a tail, then go to S_REPORT with the error flagged.
    - A head seen here is treated like S_HEAD's head (error retained for the old packet: report, then restart).
  - S_REPORT:
    - One cycle; packet_valid=1 with all summary fields.
    - No pop this cycle.
    - Then go to S_BODY if a pending head exists, else S_HEAD.
- Summary outputs hold their values between pulses; packet_valid is high for exactly one cycle.
- Flit counter saturates at all-ones (no wrap).

Optional Feature:
- Macro: PACKET_EJECTOR_CHECKSUM_EN.
- Defined: tail checksum field compared with P_CHECKSUM; mismatch sets error 6 if no earlier error.
- Undefined: checksum field ignored; error code 6 never produced.

Test Plan:
- Valid packet, id=7, src=3, dst=P_LOCAL_ID, 2 body flits, drain_en=1 → packet_valid pulse with src=3, id=7, flits=4, error=0; credit_feedback returns to `BUFFERSIZE.
- drain_en=0, push `BUFFERSIZE flits then one more → credit_feedback reaches 0, overflow=1, extra flit absent from the later report.
- Body flit with id=8 inside packet id=7 → report with packet_error=1, error_code=3, flits counted through the tail.
- Stream starts with a body then a tail → single report, error_code=1.
- Head, body, then a second head (id=9), body, tail → first report error_code=5 flits=2; second report id=9 error=0 flits=3.
- Checksum 20'h00000 in the tail:
  - With PACKET_EJECTOR_CHECKSUM_EN → error_code=6.
  - Without → error=0.
- Assert RST mid-packet → no packet_valid; credit_feedback=`BUFFERSIZE immediately.
